// File: rtl/mbm_antilog_pipe.sv
// Mitchell antilog stage: adds two log-domain operands and reinserts the leading one to form
// the approximate 2N-bit product. Two registered stages with valid/ready on both sides.
// Optional error compensation in stage 1 is enabled by defining MBM_ERR_COMP_EN.
module mbm_antilog_pipe #(
  parameter int unsigned N = 8,
  parameter int unsigned L = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [L-1:0]     k_a,
  input  logic [N-2:0]     x_a,
  input  logic             zero_a,
  input  logic [L-1:0]     k_b,
  input  logic [N-2:0]     x_b,
  input  logic             zero_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_product
);

  localparam int unsigned PW    = 2 * N;
  localparam int unsigned WideW = 3 * N - 1;

  if (2 ** L != N) begin : gen_param_check
    $error("mbm_antilog_pipe: 2**L must equal N");
  end

`ifdef MBM_ERR_COMP_EN
  localparam logic [N-1:0] CompVal = (N >= 5) ? N'(1 << (N - 5)) : '0;
`endif

  logic           s1_valid_q, s1_valid_d;
  logic [L:0]     s1_exp_q, s1_exp_d;
  logic [N-1:0]   s1_mant_q, s1_mant_d;
  logic           s1_zero_q, s1_zero_d;
  logic           out_valid_q, out_valid_d;
  logic [PW-1:0]  out_product_q, out_product_d;

  logic           s2_load;
  logic           in_xfer;
  logic [N-1:0]   frac_sum;
  logic           carry;
  logic [N-2:0]   frac;
  logic [PW-1:0]  s2_prod;
`ifdef MBM_ERR_COMP_EN
  logic [N-1:0]   frac_comp;
`endif

  // Stage 1: log-domain add; the fraction carry bumps the characteristic.
  always_comb begin
    frac_sum = {1'b0, x_a} + {1'b0, x_b};
    carry    = frac_sum[N-1];
`ifdef MBM_ERR_COMP_EN
    frac_comp = {1'b0, frac_sum[N-2:0]} + CompVal;
    frac      = frac_comp[N-1] ? '1 : frac_comp[N-2:0];
`else
    frac      = frac_sum[N-2:0];
`endif
  end

  // Stage 2: antilog is the mantissa shifted by the exponent, rescaled by the fraction width.
  always_comb begin
    s2_prod = PW'((WideW'(s1_mant_q) << s1_exp_q) >> (N - 1));
    if (s1_zero_q) begin
      s2_prod = '0;
    end
  end

  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    in_xfer  = in_valid && in_ready;

    s1_valid_d    = s1_valid_q;
    s1_exp_d      = s1_exp_q;
    s1_mant_d     = s1_mant_q;
    s1_zero_d     = s1_zero_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_exp_d  = {1'b0, k_a} + {1'b0, k_b} + {{L{1'b0}}, carry};
      s1_mant_d = {1'b1, frac};
      s1_zero_d = zero_a | zero_b;
    end

    // A bubble clears valid but leaves the last product visible.
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_product_d = s2_prod;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_exp_q      <= '0;
      s1_mant_q     <= '0;
      s1_zero_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_exp_q      <= s1_exp_d;
      s1_mant_q     <= s1_mant_d;
      s1_zero_q     <= s1_zero_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;

endmodule

// File: tb/tb_mbm_antilog_pipe.sv
// Self-checking bench for mbm_antilog_pipe: directed vectors, stall/reset sequences and a
// randomized stream scored against a fixed-point log-sum model.
module tb_mbm_antilog_pipe;

  localparam int unsigned N  = 8;
  localparam int unsigned L  = 3;
  localparam int unsigned PW = 2 * N;

`ifdef MBM_ERR_COMP_EN
  localparam logic [PW-1:0] E13x6 = 16'd76;
  localparam logic [PW-1:0] E255  = 16'd65280;
  localparam logic [PW-1:0] E3x5  = 16'd14;
  localparam logic [PW-1:0] E11x3 = 16'd31;
  localparam logic [PW-1:0] E7x3  = 16'd21;
`else
  localparam logic [PW-1:0] E13x6 = 16'd72;
  localparam logic [PW-1:0] E255  = 16'd65024;
  localparam logic [PW-1:0] E3x5  = 16'd14;
  localparam logic [PW-1:0] E11x3 = 16'd30;
  localparam logic [PW-1:0] E7x3  = 16'd20;
`endif

  typedef struct packed {
    logic [L-1:0] k;
    logic [N-2:0] x;
    logic         z;
  } op_t;

  typedef struct packed {
    op_t           a;
    op_t           b;
    logic [PW-1:0] expv;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [L-1:0]  k_a, k_b;
  logic [N-2:0]  x_a, x_b;
  logic          zero_a, zero_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_product;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [PW-1:0] exp_q[$];
  logic          smp_ir, smp_ov;
  logic [PW-1:0] smp_op, prev_op;
  logic          stall_prev = 1'b0;

  always #5 clk = ~clk;

  mbm_antilog_pipe #(.N(N), .L(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .k_a         (k_a),
    .x_a         (x_a),
    .zero_a      (zero_a),
    .k_b         (k_b),
    .x_b         (x_b),
    .zero_b      (zero_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Operand value -> (leading-one position, MSB-aligned fraction, zero flag).
  function automatic op_t enc(input int unsigned v);
    op_t o;
    int unsigned pos = 0;
    int unsigned t;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) pos = i;
    end
    t   = v << (N - 1 - pos);
    o.k = L'(pos);
    o.x = t[N-2:0];
    o.z = (v == 0);
    return o;
  endfunction

  // log2 approximations as fixed point with N-1 fraction bits; sum, then antilog.
  function automatic logic [PW-1:0] model(input op_t a, input op_t b);
    int unsigned  t, e, f;
    longint unsigned p;
    if (a.z || b.z) return '0;
    t = (int'(a.k) + int'(b.k)) * (2 ** (N - 1)) + int'(a.x) + int'(b.x);
    e = t / (2 ** (N - 1));
    f = t % (2 ** (N - 1));
`ifdef MBM_ERR_COMP_EN
    f = f + 2 ** (N - 5);
    if (f > 2 ** (N - 1) - 1) f = 2 ** (N - 1) - 1;
`endif
    p = ((64'(2 ** (N - 1)) + 64'(f)) << e) / 64'(2 ** (N - 1));
    return p[PW-1:0];
  endfunction

  // One clock: drive at posedge+1, sample and score at negedge.
  task automatic cyc(input logic iv, input op_t a, input op_t b, input logic ordy);
    in_valid  = iv;
    k_a = a.k; x_a = a.x; zero_a = a.z;
    k_b = b.k; x_b = b.x; zero_b = b.z;
    out_ready = ordy;
    @(negedge clk);
    smp_ir = in_ready;
    smp_ov = out_valid;
    smp_op = out_product;
    if (stall_prev) begin
      check("stall_valid_hold", smp_ov, 1);
      check("stall_prod_hold", smp_op, prev_op);
    end
    if (iv && smp_ir) exp_q.push_back(model(a, b));
    if (smp_ov && ordy) begin
      n_out++;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_prod", smp_op, exp_q.pop_front());
    end
    stall_prev = smp_ov && !ordy;
    prev_op    = smp_op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    op_t  nop;
    op_t  za;
    op_t  bb_a[3], bb_b[3];
    logic [PW-1:0] bb_e[3];
    op_t  st_a[4], st_b[4];
    op_t  ra, rb;
    int   idx;
    int   base;
    logic saw_low;

    nop = enc(0);
    za  = '{k: 3'd7, x: 7'h7f, z: 1'b1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    k_a = '0; x_a = '0; zero_a = 1'b0; k_b = '0; x_b = '0; zero_b = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_in_ready", in_ready, 1);

    vt[0] = '{a: enc(13),  b: enc(6),   expv: E13x6};
    vt[1] = '{a: enc(255), b: enc(255), expv: E255};
    vt[2] = '{a: enc(1),   b: enc(1),   expv: 16'd1};
    vt[3] = '{a: za,       b: enc(255), expv: 16'd0};
    vt[4] = '{a: enc(9),   b: enc(0),   expv: 16'd0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, vt[i].a, vt[i].b, 1'b1);
      check($sformatf("tbl%0d_accept", i), smp_ir, 1);
      cyc(1'b0, nop, nop, 1'b1);
      check($sformatf("tbl%0d_not_yet", i), smp_ov, 0);
      cyc(1'b0, nop, nop, 1'b1);
      check($sformatf("tbl%0d_valid", i), smp_ov, 1);
      check($sformatf("tbl%0d_prod", i), smp_op, vt[i].expv);
    end

    // Back-to-back stream at full rate.
    bb_a[0] = enc(3);  bb_b[0] = enc(5); bb_e[0] = E3x5;
    bb_a[1] = enc(11); bb_b[1] = enc(3); bb_e[1] = E11x3;
    bb_a[2] = enc(7);  bb_b[2] = enc(3); bb_e[2] = E7x3;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) cyc(1'b1, bb_a[c], bb_b[c], 1'b1);
      else       cyc(1'b0, nop, nop, 1'b1);
      if (c < 3) check("bb_in_ready", smp_ir, 1);
      if (c >= 2 && c <= 4) begin
        check("bb_valid", smp_ov, 1);
        check("bb_prod", smp_op, bb_e[c-2]);
      end
      if (c == 5) begin
        check("bubble_valid", smp_ov, 0);
        check("bubble_prod_hold", smp_op, bb_e[2]);
      end
    end

    // Four pairs with out_ready low for cycles 3..8.
    st_a[0] = enc(13);  st_b[0] = enc(6);
    st_a[1] = enc(3);   st_b[1] = enc(5);
    st_a[2] = enc(255); st_b[2] = enc(255);
    st_a[3] = enc(7);   st_b[3] = enc(3);
    idx = 0; saw_low = 1'b0; base = n_out;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) cyc(1'b1, st_a[idx], st_b[idx], !(c >= 3 && c <= 8));
      else         cyc(1'b0, nop, nop, !(c >= 3 && c <= 8));
      if (smp_ir && idx < 4) idx++;
      if (!smp_ir) saw_low = 1'b1;
      if (c == 5) begin
        check("stall_in_ready_low", smp_ir, 0);
        check("stall_out_valid", smp_ov, 1);
      end
    end
    check("stall_all_accepted", idx, 4);
    check("stall_in_ready_fell", saw_low, 1);
    check("stall_out_count", n_out - base, 4);
    check("stall_sb_drained", exp_q.size(), 0);

    // Asynchronous reset with both stages full.
    cyc(1'b1, enc(13), enc(6), 1'b0);
    cyc(1'b1, enc(11), enc(3), 1'b0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_prod", out_product, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, enc(3), enc(5), 1'b1);
    check("post_rst_accept", smp_ir, 1);
    cyc(1'b0, nop, nop, 1'b1);
    check("post_rst_not_yet", smp_ov, 0);
    cyc(1'b0, nop, nop, 1'b1);
    check("post_rst_valid", smp_ov, 1);
    check("post_rst_prod", smp_op, E3x5);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      ra.k = L'($urandom_range(0, 2 ** L - 1));
      ra.x = (N - 1)'($urandom_range(0, 2 ** (N - 1) - 1));
      ra.z = ($urandom_range(0, 7) == 0);
      rb.k = L'($urandom_range(0, 2 ** L - 1));
      rb.x = (N - 1)'($urandom_range(0, 2 ** (N - 1) - 1));
      rb.z = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 10; c++) begin
      if (exp_q.size() != 0) cyc(1'b0, nop, nop, 1'b1);
    end
    check("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbm_antilog_pipe.md
Name: mbm_antilog_pipe

Overview:
- Downstream neighbour of the mantissa barrel-shift stage in the Mitchell-based multiplier (MBM) datapath.
- Consumes the log-domain pair (k, x) for each of two operands and adds them in the log domain.
- Performs the Mitchell antilog (leading-one reinsertion plus left shift) to produce the approximate 2N-bit product.
- Two-stage registered pipeline with valid/ready handshake on both sides, so it can sit between the log converters and the accumulator or writeback.

Parameters:
- N, 8: operand width in bits. Fraction width is N-1, product width is 2N.
- L, 3: characteristic (k) width in bits. Constraint: 2^L == N; the build fails with an elaboration error otherwise.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- k_a  in  L  leading-one position of operand A.
- x_a  in  N-1  fraction of operand A, MSB-aligned (bits below the leading one).
- zero_a  in  1  operand A is zero; k_a and x_a are don't-care.
- k_b, x_b, zero_b  in  L, N-1, 1  same fields for operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_product  out  2N  approximate product.

Behaviour:
- Reset values: out_valid=0, out_product=0, all internal stage-valid flags 0. in_ready=1 while the pipe is empty, including during and after reset.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (registered on input transfer):
  - s = x_a + x_b, N bits; c = s[N-1].
  - e = k_a + k_b + c, L+1 bits, no overflow possible.
  - m = {1'b1, s[N-2:0]}, N bits.
  - z = zero_a | zero_b.
- Stage 2 (registered when stage 1 advances):
  - P = (m << e) >> (N-1), computed at 2N+N-1 bits and truncated to 2N.
  - If z is set, P = 0.
  - out_product = P, out_valid = 1.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 pair per cycle.
- Flow control:
  - Stage 2 loads when it is empty or its output transfers this cycle.
  - Stage 1 advances whenever stage 2 loads.
  - in_ready = !s1_valid || stage-2-load. This is combinational; there is no combinational path from in_valid to in_ready.
- Stall (out_ready=0 with both stages full):
  - in_ready=0.
  - out_product and out_valid hold stable until accepted.
  - No data is lost or duplicated.
- Simultaneous output transfer and input transfer in a full pipe: both stages shift and the new pair enters stage 1 in the same cycle.
- out_product only changes on a stage-2 load. A bubble clears out_valid but leaves out_product holding its last value.
- Reset mid-operation: all in-flight pairs are discarded immediately (asynchronous), out_valid drops in the same instant, and the first post-reset product is the first pair accepted after deassertion.
- Ordering is strictly FIFO; there are no skips and no reordering.

Optional Feature:
- Macro: MBM_ERR_COMP_EN.
- Defined:
  - Stage 1 adds the constant compensation 2^(N-5) (0x08 for N=8) to s[N-2:0] after the carry is extracted.
  - The sum saturates at all-ones N-1 bits.
  - m uses the compensated fraction. Latency and handshake are unchanged.
- Undefined: plain Mitchell antilog exactly as described in Behaviour.

Test Plan:
- 13x6: k_a=3, x_a=0x50, k_b=2, x_b=0x40, out_ready=1 -> out_product=72 two cycles later. With MBM_ERR_COMP_EN -> 76.
- 255x255: k=7, x=0x7F on both -> 65024. With MBM_ERR_COMP_EN the fraction saturates to 0x7F -> 65280.
- 1x1 (k=0, x=0 both) -> 1. Then zero_a=1 with k_a=7, x_a=0x7F, and B=255 -> 0.
- Back-to-back stream 3x5, 11x3, 7x3 with out_ready=1 -> 14, 30, 20 on consecutive cycles; in_ready stays 1 throughout.
- Stream of 4 pairs with out_ready=0 for cycles 3-8:
  - in_ready falls once both stages are full.
  - out_product stays stable during the stall.
  - All 4 products appear in order after out_ready rises, with no duplicates.
- Assert rst for 1 cycle while both stages are full -> out_valid=0 at once and out_product=0. The next accepted pair 3x5 yields 14 after 2 cycles.
